// File: rtl/pipearch_fifo_source.sv
// Single-clock BRAM-backed FIFO, source end of the fifobram protocol.
// One-cycle registered read, no write-to-read fall-through, sticky overflow.
module pipearch_fifo_source #(
  parameter int unsigned WIDTH             = 32,
  parameter int unsigned LOG2_DEPTH        = 5,
  parameter int unsigned ALMOSTFULL_MARGIN = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  output logic [WIDTH-1:0]      rdata,
  output logic                  rvalid,
  output logic                  almostfull,
  output logic                  empty,
  output logic [LOG2_DEPTH-1:0] count,
  output logic                  overflow
);

  localparam int unsigned DEPTH = 1 << LOG2_DEPTH;
  localparam logic [LOG2_DEPTH-1:0] CAP_V = LOG2_DEPTH'(DEPTH - 1);
  localparam logic [LOG2_DEPTH-1:0] AF_V  = LOG2_DEPTH'(DEPTH - 1 - ALMOSTFULL_MARGIN);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [LOG2_DEPTH-1:0] wptr_q, wptr_d;
  logic [LOG2_DEPTH-1:0] rptr_q, rptr_d;
  logic [LOG2_DEPTH-1:0] count_q, count_d;
  logic                  empty_q, empty_d;
  logic                  almostfull_q, almostfull_d;
  logic                  overflow_q, overflow_d;
  logic                  rvalid_q, rvalid_d;
  logic [WIDTH-1:0]      rdata_q;
  logic                  rd_ok, wr_ok;

  always_comb begin
    rd_ok        = re && (count_q != '0);
    // A full FIFO still takes a write when a read frees a slot this cycle.
    wr_ok        = we && ((count_q != CAP_V) || rd_ok);
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    if (wr_ok) wptr_d = wptr_q + LOG2_DEPTH'(1);
    if (rd_ok) rptr_d = rptr_q + LOG2_DEPTH'(1);
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + LOG2_DEPTH'(1);
      2'b01:   count_d = count_q - LOG2_DEPTH'(1);
      default: count_d = count_q;
    endcase
    empty_d      = (count_d == '0);
    almostfull_d = (count_d >= AF_V);
    overflow_d   = overflow_q || (we && !wr_ok);
    rvalid_d     = rd_ok;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      empty_q      <= 1'b1;
      almostfull_q <= 1'b0;
      overflow_q   <= 1'b0;
      rvalid_q     <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      empty_q      <= empty_d;
      almostfull_q <= almostfull_d;
      overflow_q   <= overflow_d;
      rvalid_q     <= rvalid_d;
    end
  end

  // Memory itself is never reset so it maps onto a plain dual-port BRAM.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset)      rdata_q <= '0;
    else if (rd_ok) rdata_q <= mem[rptr_q];
  end

  assign rdata      = rdata_q;
  assign rvalid     = rvalid_q;
  assign almostfull = almostfull_q;
  assign empty      = empty_q;
  assign count      = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_pipearch_fifo_source.sv
// Directed bench for pipearch_fifo_source (LOG2_DEPTH=5, margin 4: CAP=31, threshold 27).
module tb_pipearch_fifo_source;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic        re = 1'b0;
  logic [31:0] rdata;
  logic        rvalid;
  logic        almostfull;
  logic        empty;
  logic [4:0]  count;
  logic        overflow;

  int compared = 0;
  int mismatched = 0;

  pipearch_fifo_source #(
    .WIDTH(32),
    .LOG2_DEPTH(5),
    .ALMOSTFULL_MARGIN(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .we(we),
    .wdata(wdata),
    .re(re),
    .rdata(rdata),
    .rvalid(rvalid),
    .almostfull(almostfull),
    .empty(empty),
    .count(count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // 1: reset, idle, reads while empty
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_af", 32'(almostfull), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    re = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("empty_re_rvalid", 32'(rvalid), 32'd0);
      chk("empty_re_count", 32'(count), 32'd0);
    end
    re = 1'b0;

    // 2: five writes then five back-to-back reads
    we = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wdata = 32'h10 + 32'(i);
      tick();
      chk("s2_wr_count", 32'(count), 32'(i + 1));
      chk("s2_wr_empty", 32'(empty), 32'd0);
    end
    we = 1'b0;
    re = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s2_rvalid", 32'(rvalid), 32'd1);
      chk("s2_rdata", rdata, 32'h10 + 32'(i));
      chk("s2_count", 32'(count), 32'(4 - i));
    end
    chk("s2_empty", 32'(empty), 32'd1);
    re = 1'b0;
    tick();
    chk("s2_rvalid_end", 32'(rvalid), 32'd0);
    chk("s2_rdata_hold", rdata, 32'h14);

    // 3: fill to almostfull, to full, then overflow
    we = 1'b1;
    for (int i = 0; i < 27; i++) begin
      wdata = 32'h100 + 32'(i);
      tick();
      if (i == 25) chk("s3_af_26", 32'(almostfull), 32'd0);
    end
    chk("s3_af_27", 32'(almostfull), 32'd1);
    chk("s3_count_27", 32'(count), 32'd27);
    for (int i = 27; i < 31; i++) begin
      wdata = 32'h100 + 32'(i);
      tick();
    end
    chk("s3_count_31", 32'(count), 32'd31);
    chk("s3_ovf_full", 32'(overflow), 32'd0);
    wdata = 32'h1FF;
    tick();
    chk("s3_ovf_set", 32'(overflow), 32'd1);
    chk("s3_count_drop", 32'(count), 32'd31);
    we = 1'b0;
    re = 1'b1;
    for (int i = 0; i < 31; i++) begin
      tick();
      chk("s3_rdata", rdata, 32'h100 + 32'(i));
      if (i == 4) chk("s3_af_fall", 32'(almostfull), 32'd0);
    end
    re = 1'b0;
    tick();
    chk("s3_count_0", 32'(count), 32'd0);
    chk("s3_ovf_sticky", 32'(overflow), 32'd1);

    // 4: simultaneous write and read while full
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("s4_ovf_cleared", 32'(overflow), 32'd0);
    we = 1'b1;
    for (int i = 0; i < 31; i++) begin
      wdata = 32'h200 + 32'(i);
      tick();
    end
    chk("s4_full", 32'(count), 32'd31);
    wdata = 32'hAB;
    re = 1'b1;
    tick();
    chk("s4_count", 32'(count), 32'd31);
    chk("s4_ovf", 32'(overflow), 32'd0);
    chk("s4_first", rdata, 32'h200);
    we = 1'b0;
    for (int i = 1; i < 31; i++) begin
      tick();
      chk("s4_drain", rdata, 32'h200 + 32'(i));
    end
    tick();
    chk("s4_last", rdata, 32'hAB);
    chk("s4_empty", 32'(empty), 32'd1);
    re = 1'b0;

    // 5: streaming at count=2 across several pointer wraps
    we = 1'b1;
    wdata = 32'hC0; tick();
    wdata = 32'hC1; tick();
    chk("s5_pre_count", 32'(count), 32'd2);
    re = 1'b1;
    for (int k = 0; k < 100; k++) begin
      wdata = 32'(k);
      tick();
      chk("s5_count", 32'(count), 32'd2);
      chk("s5_rvalid", 32'(rvalid), 32'd1);
      if (k == 0)      chk("s5_rdata", rdata, 32'hC0);
      else if (k == 1) chk("s5_rdata", rdata, 32'hC1);
      else             chk("s5_rdata", rdata, 32'(k - 2));
    end
    we = 1'b0;
    tick();
    chk("s5_tail98", rdata, 32'd98);
    tick();
    chk("s5_tail99", rdata, 32'd99);
    chk("s5_empty", 32'(empty), 32'd1);
    re = 1'b0;
    tick();

    // 6: write+read on empty, then reset during an accepted read
    we = 1'b1; re = 1'b1; wdata = 32'h55;
    tick();
    chk("s6_rvalid0", 32'(rvalid), 32'd0);
    chk("s6_count1", 32'(count), 32'd1);
    we = 1'b0;
    tick();
    chk("s6_rvalid1", 32'(rvalid), 32'd1);
    chk("s6_rdata", rdata, 32'h55);
    re = 1'b0;
    we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wdata = 32'h60 + 32'(i);
      tick();
    end
    we = 1'b0;
    chk("s6_count3", 32'(count), 32'd3);
    re = 1'b1;
    reset = 1'b1;
    tick();
    chk("s6_rst_rvalid", 32'(rvalid), 32'd0);
    chk("s6_rst_count", 32'(count), 32'd0);
    chk("s6_rst_empty", 32'(empty), 32'd1);
    chk("s6_rst_rdata", rdata, 32'd0);
    reset = 1'b0;
    re = 1'b0;
    tick();
    chk("s6_post_rvalid", 32'(rvalid), 32'd0);
    chk("s6_post_count", 32'(count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipearch_fifo_source.md
# pipearch_fifo_source

Synchronous single-clock BRAM-backed FIFO implementing the source end of the `fifobram_interface` FIFO protocol: it drives `rdata`, `rvalid`, `almostfull`, `empty` and `count` toward a `fifo_write` producer and a `fifo_read` consumer. It is used wherever a pipeline stage buffers data between a memory-read engine and a compute unit, for example the prefetch and internal buffers sized by `LOG2_PREFETCH_SIZE` and `LOG2_INTERNAL_SIZE`. Read data has one-cycle BRAM latency, and the block never falls through from write to read.

## Interface

Parameters:
- `WIDTH`, 32: data word width.
- `LOG2_DEPTH`, 5: address width. Memory has 2**`LOG2_DEPTH` entries; usable capacity is CAP = 2**`LOG2_DEPTH` - 1.
- `ALMOSTFULL_MARGIN`, 4: free-slot margin. Must satisfy 0 ≤ margin < CAP.

Ports (reset is synchronous and active-high):
- `clk` in 1: single clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `we` in 1: write request.
- `wdata` in `WIDTH`: write data, sampled when `we`=1.
- `re` in 1: read request.
- `rdata` out `WIDTH`: read data; valid when `rvalid`=1.
- `rvalid` out 1: read data valid, one cycle after an accepted read.
- `almostfull` out 1: registered; high when `count` ≥ CAP - `ALMOSTFULL_MARGIN`.
- `empty` out 1: registered; high when `count` == 0.
- `count` out `LOG2_DEPTH`: registered occupancy, 0..CAP.
- `overflow` out 1: sticky flag, set when a write is dropped.

## Operation

- State consists of the write pointer `wptr`, read pointer `rptr` (both `LOG2_DEPTH` bits, wrapping modulo 2**`LOG2_DEPTH`), `count`, and the memory array.
- Read accept: `rd_ok` = `re` & (`count` != 0). A read with `re`=1 while empty is ignored and causes no pointer change. This is not an error.
- Write accept: `wr_ok` = `we` & ((`count` != CAP) | `rd_ok`).
  - A write while full is accepted only if a read is accepted in the same cycle.
  - Otherwise the write is dropped and `overflow` is set to 1. `overflow` is cleared only by `reset`.
- On `wr_ok`: mem[`wptr`] ← `wdata`, then `wptr` ← `wptr`+1.
- On `rd_ok`: `rdata` ← mem[`rptr`] (registered), then `rptr` ← `rptr`+1.
- `count` update:
  - +1 when `wr_ok` & !`rd_ok`.
  - -1 when `rd_ok` & !`wr_ok`.
  - Unchanged when both or neither are accepted.
- `empty` and `almostfull` are registered from the next-state `count`, so they are always consistent with `count` in the same cycle.
- No fall-through: a word written at cycle t is readable (`rd_ok`) at the earliest in cycle t+1, because `empty` and `count` reflect it from t+1.
- When `count`==0, a simultaneous `we` and `re` accepts the write and ignores the read.
- Reset in the middle of operation:
  - Pointers, `count`, flags, `rvalid` and `rdata` are cleared.
  - A read accepted in the cycle `reset` is asserted produces no `rvalid`.
  - Memory contents are not cleared.
- Order is strictly first-in first-out. Pointer wrap is transparent to the user.

## Timing

- Reset values:
  - `rdata` = 0, `rvalid` = 0
  - `empty` = 1, `almostfull` = 0 (given margin < CAP)
  - `count` = 0, `overflow` = 0
  - Internal `wptr` = `rptr` = 0
- Read latency is 1: `rd_ok` at cycle t gives `rvalid`=1 and `rdata` at t+1.
- `rvalid` is a single-cycle pulse per accepted read. Back-to-back reads give back-to-back `rvalid`.
- `rdata` holds its last value while `rvalid`=0.
- `count`, `empty`, `almostfull` and `overflow` update at the edge that ends the cycle of the triggering request.
- Producer contract: stop issuing writes once `almostfull`=1. The margin absorbs up to `ALMOSTFULL_MARGIN` in-flight writes.
- Throughput is one write and one read per cycle sustained.
- The memory must infer a simple dual-port BRAM with a registered read port. There is no output register stage beyond `rdata`.

## Test plan

All scenarios use `LOG2_DEPTH`=5 and margin 4, so CAP=31 and the almostfull threshold is 27.

1. Reset, then idle → `empty`=1, `count`=0, `rvalid`=0, `almostfull`=0, `overflow`=0. Then assert `re` for 3 cycles → no `rvalid` and no pointer change.
2. Write 0x10..0x14 (5 words), then 5 consecutive `re` → `rvalid` pulses on 5 consecutive cycles, each one cycle after its `re`, with `rdata` 0x10..0x14 in order. `count` goes 5→0 and `empty`=1 after the last read.
3. Write 27 words → `almostfull` rises in the cycle after the 27th write (`count`=27). Write 4 more → `count`=31. A 32nd write is dropped, `overflow`=1 and `count` stays 31. Reading all 31 returns the first 31 values in order.
4. With the FIFO full (`count`=31), assert `we`=1 and `re`=1 together with `wdata`=0xAB → write accepted, `count` stays 31, `overflow` stays 0. After draining, 0xAB is the last word out.
5. Write and read streaming simultaneously for 100 cycles with values 0..99, starting from `count`=2 → `count` constant at 2, pointers wrap at least 3 times, and the output sequence is exactly the prior 2 words followed by 0..97.
6. With `count`=0, issue `we`=1 and `re`=1 in the same cycle with 0x55 → `rvalid`=0 next cycle and `count`=1; `re` in the following cycle gives 0x55 one cycle later. Then, with 3 words stored and `re` accepted, assert `reset` in the same cycle → `rvalid`=0, `count`=0, `empty`=1 afterward.
